// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encodings,
// default parameter values and the zero-fill helper macro.
`ifndef PIPELINE_CTRL_PKG_SV
`define PIPELINE_CTRL_PKG_SV

`define CLEAR(width) {(width){1'b0}}

package pipeline_ctrl_pkg;

   localparam int DEFAULT_REG_ADDR_SIZE    = 5;
   localparam int DEFAULT_CYCLE_COUNT_SIZE = 32;
   localparam int DEFAULT_DRAIN_CYCLES     = 4;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RUN       = 3'd1;
   localparam logic [2:0] S_STEP_WAIT = 3'd2;
   localparam logic [2:0] S_STEP_EXEC = 3'd3;
   localparam logic [2:0] S_DRAIN     = 3'd4;
   localparam logic [2:0] S_HALTED    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_RUN       = S_RUN,
      ST_STEP_WAIT = S_STEP_WAIT,
      ST_STEP_EXEC = S_STEP_EXEC,
      ST_DRAIN     = S_DRAIN,
      ST_HALTED    = S_HALTED
   } state_t;

   // Any state in which the debug unit should see the core as active.
   function automatic logic is_running(state_t s);
      return (s == ST_RUN) || (s == ST_STEP_WAIT) || (s == ST_STEP_EXEC) || (s == ST_DRAIN);
   endfunction

endpackage

`endif

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: the IF/ID instruction reads a register that the
// load currently in ID/EX has not yet written.
module hazard_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_SIZE = DEFAULT_REG_ADDR_SIZE
) (
   input  logic                     i_id_ex_mem_read,
   input  logic [REG_ADDR_SIZE-1:0] i_id_ex_rt,
   input  logic [REG_ADDR_SIZE-1:0] i_if_id_rs,
   input  logic [REG_ADDR_SIZE-1:0] i_if_id_rt,
   output logic                     o_stall
);

   // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign o_stall = i_id_ex_mem_read
                 && (i_id_ex_rt != `CLEAR(REG_ADDR_SIZE))
                 && ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage pipeline: run/single-step execution,
// load-use stall, taken-branch flush and HALT drain.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_SIZE    = DEFAULT_REG_ADDR_SIZE,
   parameter int CYCLE_COUNT_SIZE = DEFAULT_CYCLE_COUNT_SIZE,
   parameter int DRAIN_CYCLES     = DEFAULT_DRAIN_CYCLES
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic                        i_step_mode,
   input  logic                        i_step,
   input  logic                        i_halt_in_id,
   input  logic                        i_branch_taken,
   input  logic                        i_id_ex_mem_read,
   input  logic [REG_ADDR_SIZE-1:0]    i_id_ex_rt,
   input  logic [REG_ADDR_SIZE-1:0]    i_if_id_rs,
   input  logic [REG_ADDR_SIZE-1:0]    i_if_id_rt,
   output logic                        o_pc_enable,
   output logic                        o_if_id_enable,
   output logic                        o_if_id_flush,
   output logic                        o_id_ex_bubble,
   output logic                        o_stage_enable,
   output logic                        o_running,
   output logic                        o_halted,
   output logic [CYCLE_COUNT_SIZE-1:0] o_cycles
);

   localparam int                DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   state_t             state, next_state;
   logic [DRAIN_W-1:0] drain_cnt, drain_next;
   logic               load_use_stall;

   hazard_detect #(
      .REG_ADDR_SIZE (REG_ADDR_SIZE)
   ) u_hazard_detect (
      .i_id_ex_mem_read (i_id_ex_mem_read),
      .i_id_ex_rt       (i_id_ex_rt),
      .i_if_id_rs       (i_if_id_rs),
      .i_if_id_rt       (i_if_id_rt),
      .o_stall          (load_use_stall)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      next_state     = state;
      drain_next     = drain_cnt;
      o_pc_enable    = 1'b0;
      o_if_id_enable = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_stage_enable = 1'b0;

      case (state)
         ST_IDLE: begin
            if (i_start) next_state = i_step_mode ? ST_STEP_WAIT : ST_RUN;
         end
         ST_STEP_WAIT: begin
            if (i_step) next_state = ST_STEP_EXEC;
         end
         ST_RUN, ST_STEP_EXEC: begin
            o_pc_enable    = 1'b1;
            o_if_id_enable = 1'b1;
            o_stage_enable = 1'b1;
            if (state == ST_STEP_EXEC) next_state = ST_STEP_WAIT;
            // Halt outranks the stall so the HALT itself always reaches ID/EX and drains.
            if (i_halt_in_id) begin
               o_pc_enable   = 1'b0;
               o_if_id_flush = 1'b1;
               next_state    = ST_DRAIN;
               drain_next    = DRAIN_LOAD;
            end else if (load_use_stall) begin
               o_pc_enable    = 1'b0;
               o_if_id_enable = 1'b0;
               o_id_ex_bubble = 1'b1;
            end else if (i_branch_taken) begin
               o_if_id_flush = 1'b1;
            end
         end
         ST_DRAIN: begin
            o_stage_enable = 1'b1;
            if (drain_cnt == `CLEAR(DRAIN_W)) next_state = ST_HALTED;
            else                              drain_next = drain_cnt - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         drain_cnt <= `CLEAR(DRAIN_W);
         o_running <= 1'b0;
         o_halted  <= 1'b0;
         o_cycles  <= `CLEAR(CYCLE_COUNT_SIZE);
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         state     <= next_state;
         drain_cnt <= drain_next;
         o_running <= is_running(next_state);
         o_halted  <= (next_state == ST_HALTED);
         if (o_stage_enable && (o_cycles != {CYCLE_COUNT_SIZE{1'b1}}))
            o_cycles <= o_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl against a behavioural model of
// run/step sequencing, stalls, flushes, drain and cycle counting.
module tb_pipeline_ctrl;

   localparam int RA = 5;
   localparam int CW = 6;
   localparam int DC = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic          pc;
      logic          ifid;
      logic          flush;
      logic          bubble;
      logic          stage;
      logic          running;
      logic          halted;
      logic [CW-1:0] cycles;
   } obs_t;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_start = 1'b0, i_step_mode = 1'b0, i_step = 1'b0;
   logic          i_halt_in_id = 1'b0, i_branch_taken = 1'b0, i_id_ex_mem_read = 1'b0;
   logic [RA-1:0] i_id_ex_rt = '0, i_if_id_rs = '0, i_if_id_rt = '0;
   logic          o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble, o_stage_enable;
   logic          o_running, o_halted;
   logic [CW-1:0] o_cycles;

   pipeline_ctrl #(
      .REG_ADDR_SIZE    (RA),
      .CYCLE_COUNT_SIZE (CW),
      .DRAIN_CYCLES     (DC)
   ) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .i_step_mode      (i_step_mode),
      .i_step           (i_step),
      .i_halt_in_id     (i_halt_in_id),
      .i_branch_taken   (i_branch_taken),
      .i_id_ex_mem_read (i_id_ex_mem_read),
      .i_id_ex_rt       (i_id_ex_rt),
      .i_if_id_rs       (i_if_id_rs),
      .i_if_id_rt       (i_if_id_rt),
      .o_pc_enable      (o_pc_enable),
      .o_if_id_enable   (o_if_id_enable),
      .o_if_id_flush    (o_if_id_flush),
      .o_id_ex_bubble   (o_id_ex_bubble),
      .o_stage_enable   (o_stage_enable),
      .o_running        (o_running),
      .o_halted         (o_halted),
      .o_cycles         (o_cycles)
   );

   always #5 i_clk = ~i_clk;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_no = 0;

   // Reference model: what the controller has been told to do, not how it encodes it.
   bit          m_started, m_step_mode, m_step_granted, m_halted;
   int          m_drain_left;
   int unsigned m_cycles;

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual pc=%b ifid=%b flush=%b bubble=%b stage=%b run=%b halt=%b cyc=%0d, required pc=%b ifid=%b flush=%b bubble=%b stage=%b run=%b halt=%b cyc=%0d",
                  name, act.pc, act.ifid, act.flush, act.bubble, act.stage, act.running, act.halted, act.cycles,
                  exp.pc, exp.ifid, exp.flush, exp.bubble, exp.stage, exp.running, exp.halted, exp.cycles);
      end
   endtask

   task automatic model_reset();
      m_started      = 0;
      m_step_mode    = 0;
      m_step_granted = 0;
      m_halted       = 0;
      m_drain_left   = -1;
      m_cycles       = 0;
   endtask

   // Predict this cycle's outputs from current inputs, queue them, then advance the model.
   task automatic model_cycle();
      obs_t e;
      bit   hazard, advance;
      e = '0;
      if (i_reset) begin
         model_reset();
         exp_q.push_back(e);
         return;
      end
      hazard  = i_id_ex_mem_read && (i_id_ex_rt != 0) &&
                ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
      advance = m_started && !m_halted && (m_drain_left < 0) && (!m_step_mode || m_step_granted);
      e.running = m_started && !m_halted;
      e.halted  = m_halted;
      e.cycles  = CW'(m_cycles);
      if (advance) begin
         e.pc = 1; e.ifid = 1; e.stage = 1;
         if (i_halt_in_id)        begin e.pc = 0; e.flush = 1; end
         else if (hazard)         begin e.pc = 0; e.ifid = 0; e.bubble = 1; end
         else if (i_branch_taken) e.flush = 1;
      end else if (m_drain_left >= 0) begin
         e.stage = 1;
      end
      exp_q.push_back(e);

      if (e.stage && m_cycles < CMAX) m_cycles++;
      if (m_drain_left >= 0) begin
         if (m_drain_left == 0) begin m_halted = 1; m_drain_left = -1; end
         else m_drain_left--;
      end else if (advance) begin
         m_step_granted = 0;
         if (i_halt_in_id) m_drain_left = DC - 1;
      end else if (!m_started) begin
         if (i_start) begin
            m_started      = 1;
            m_step_mode    = i_step_mode;
            m_step_granted = 0;
         end
      end else if (m_step_mode && !m_halted && i_step) begin
         m_step_granted = 1;
      end
   endtask

   task automatic cyc(input logic rst, input logic st, input logic sm, input logic stp,
                      input logic hlt, input logic br, input logic mr,
                      input logic [RA-1:0] exrt, input logic [RA-1:0] rs, input logic [RA-1:0] rt);
      @(posedge i_clk);
      #1;
      i_reset = rst; i_start = st; i_step_mode = sm; i_step = stp;
      i_halt_in_id = hlt; i_branch_taken = br; i_id_ex_mem_read = mr;
      i_id_ex_rt = exrt; i_if_id_rs = rs; i_if_id_rt = rt;
      model_cycle();
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
   endtask

   // Small register numbers keep load-use matches frequent.
   task automatic rnd_cyc(input bit allow_halt, input int step_pct);
      cyc(0, ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
          ($urandom_range(0, 99) < step_pct),
          allow_halt && ($urandom_range(0, 15) == 0),
          $urandom_range(0, 1), $urandom_range(0, 1),
          RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)));
   endtask

   always @(negedge i_clk) begin
      obs_t act, e;
      cyc_no++;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = '{o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble,
                 o_stage_enable, o_running, o_halted, o_cycles};
         check($sformatf("cycle%0d", cyc_no), act, e);
      end
   end

   initial begin
      model_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);

      // Free run start and counting.
      cyc(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
      repeat (4) idle_cyc();
      // Load-use stall, then a load to r0 that must not stall.
      cyc(0, 0, 0, 0, 0, 0, 1, RA'(5), RA'(5), RA'(2));
      cyc(0, 0, 0, 0, 0, 0, 1, RA'(0), RA'(0), RA'(0));
      // Stall beats branch; branch alone flushes.
      cyc(0, 0, 0, 0, 0, 1, 1, RA'(7), RA'(1), RA'(7));
      cyc(0, 0, 0, 0, 0, 1, 0, RA'(7), RA'(1), RA'(7));
      repeat (40) rnd_cyc(0, 20);
      // Halt, drain, then start/halt/hazard while halted are all ignored.
      cyc(0, 0, 0, 0, 1, 0, 0, '0, '0, '0);
      repeat (4) idle_cyc();
      cyc(0, 1, 0, 0, 1, 1, 1, RA'(3), RA'(3), RA'(3));
      repeat (3) idle_cyc();

      // Single-step: three pulses; the last one held into STEP_EXEC.
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      cyc(0, 1, 1, 0, 0, 0, 0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
         repeat (4) idle_cyc();
         cyc(0, 0, 0, 1, 0, 0, 0, '0, '0, '0);
         if (k == 2) cyc(0, 0, 0, 1, 0, 0, 0, '0, '0, '0);
      end
      repeat (5) idle_cyc();
      repeat (80) rnd_cyc(1, 35);

      // Reset in the middle of a drain, then restart.
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      cyc(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
      idle_cyc();
      cyc(0, 0, 0, 0, 1, 0, 0, '0, '0, '0);
      repeat (2) idle_cyc();
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      cyc(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
      repeat (3) idle_cyc();

      // Long free run to saturate the cycle counter.
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      cyc(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
      repeat (75) rnd_cyc(0, 10);

      @(posedge i_clk);
      @(negedge i_clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_queue: actual %0d pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
